// File: rtl/sha3_miner_pkg.sv
// Shared constants and helpers for the SHA3 miner CSR block.
// Address map, control layout and byte-merge helper.
package sha3_miner_pkg;

  localparam logic [31:0] VERSION_DEF = 32'h5348_3301;

  localparam logic [4:0] ADDR_HEADER0  = 5'h00;
  localparam logic [4:0] ADDR_DIFF0    = 5'h08;
  localparam logic [4:0] ADDR_NONCE_LO = 5'h10;
  localparam logic [4:0] ADDR_NONCE_HI = 5'h11;
  localparam logic [4:0] ADDR_CONTROL  = 5'h12;
  localparam logic [4:0] ADDR_STATUS   = 5'h13;
  localparam logic [4:0] ADDR_SOL_LO   = 5'h14;
  localparam logic [4:0] ADDR_SOL_HI   = 5'h15;
  localparam logic [4:0] ADDR_IRQ_PEND = 5'h16;
  localparam logic [4:0] ADDR_IRQ_EN   = 5'h17;
  localparam logic [4:0] ADDR_VERSION  = 5'h18;

  localparam int JOB_WORDS = 18;
  localparam int JOB_W     = 32 * JOB_WORDS;

  // control[18:0] = {padf[18:11], padl[10:3], halt, test, run}
  typedef struct packed {
    logic [7:0] padf;
    logic [7:0] padl;
    logic       halt;
    logic       test;
    logic       run;
  } ctrl_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sha3_miner_csr_if.sv
// Avalon-MM slave bus bundle for the miner CSR block.
// Host drives the request, CSR returns read data.
interface sha3_miner_csr_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/csr_byte_reg32.sv
// 32-bit register with per-byte write enables.
// A high lock input drops the write entirely.
module csr_byte_reg32
  import sha3_miner_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        lock,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // byte-merged write unless locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (we && !lock)
      q <= be_merge(q, wdata, be);
  end

endmodule

// File: rtl/sha3_miner_csr.sv
// Avalon-MM register file in front of sha3_256_miner.
// Job regs lock while running; irq is pending & enable.
module sha3_miner_csr
  import sha3_miner_pkg::*;
#(
  parameter logic [31:0] VERSION = VERSION_DEF,
  parameter int          ADDR_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  sha3_miner_csr_if.slave avs,
  output logic [255:0]   header,
  output logic [255:0]   difficulty,
  output logic [63:0]    start_nonce,
  output logic [18:0]    control,
  input  logic [63:0]    solution,
  input  logic [2:0]     status,
  input  logic           miner_irq,
  output logic           irq
);

  localparam int HDR_BASE   = 32 * int'(ADDR_HEADER0);
  localparam int DIFF_BASE  = 32 * int'(ADDR_DIFF0);
  localparam int NONCE_BASE = 32 * int'(ADDR_NONCE_LO);

  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              wr;
  logic              rd;
  logic              job_hit;
  logic [JOB_W-1:0]  job;
  ctrl_t             ctrl;
  logic              lock_err;
  logic              pending;
  logic              enable;
  logic              miner_irq_d;
  logic [31:0]       snapshot;
  logic [31:0]       rdata;

  assign addr    = avs.address;
  assign be      = avs.byteenable;
  assign wdata   = avs.writedata;
  assign wr      = avs.write;
  assign rd      = avs.read & ~avs.write;
  assign job_hit = addr <= ADDR_W'(ADDR_NONCE_HI);

  for (genvar i = 0; i < JOB_WORDS; i++) begin : g_job
    csr_byte_reg32 u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr && (addr == ADDR_W'(i))),
      .lock  (ctrl.run),
      .be    (be),
      .wdata (wdata),
      .q     (job[32*i +: 32])
    );
  end

  assign header      = job[DIFF_BASE-1:HDR_BASE];
  assign difficulty  = job[NONCE_BASE-1:DIFF_BASE];
  assign start_nonce = job[NONCE_BASE +: 64];
  assign control     = ctrl;

  // control register, byte-enabled, never locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (wr && addr == ADDR_W'(ADDR_CONTROL)) begin
      if (be[0]) ctrl[7:0]   <= wdata[7:0];
      if (be[1]) ctrl[15:8]  <= wdata[15:8];
      if (be[2]) ctrl[18:16] <= wdata[18:16];
    end
  end

  // sticky lock error, cleared by W1C on status bit3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_err <= 1'b0;
    else if (wr && job_hit && ctrl.run)
      lock_err <= 1'b1;
    else if (wr && addr == ADDR_W'(ADDR_STATUS)
             && be[0] && wdata[3])
      lock_err <= 1'b0;
  end

  // irq edge capture; a new edge beats a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miner_irq_d <= 1'b0;
      pending     <= 1'b0;
      enable      <= 1'b0;
      irq         <= 1'b0;
    end else begin
      miner_irq_d <= miner_irq;
      if (miner_irq && !miner_irq_d)
        pending <= 1'b1;
      else if (wr && addr == ADDR_W'(ADDR_IRQ_PEND)
               && be[0] && wdata[0])
        pending <= 1'b0;
      if (wr && addr == ADDR_W'(ADDR_IRQ_EN) && be[0])
        enable <= wdata[0];
      irq <= pending & enable;
    end
  end

  // read data select
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      job_hit:
        rdata = job[{addr, 5'b0} +: 32];
      addr == ADDR_W'(ADDR_CONTROL):
        rdata = {13'b0, ctrl};
      addr == ADDR_W'(ADDR_STATUS):
        rdata = {28'b0, lock_err, status};
      addr == ADDR_W'(ADDR_SOL_LO):
        rdata = solution[31:0];
      addr == ADDR_W'(ADDR_SOL_HI):
        rdata = snapshot;
      addr == ADDR_W'(ADDR_IRQ_PEND):
        rdata = {31'b0, pending};
      addr == ADDR_W'(ADDR_IRQ_EN):
        rdata = {31'b0, enable};
      addr == ADDR_W'(ADDR_VERSION):
        rdata = VERSION;
      default:
        rdata = '0;
    endcase
  end

  // 1-cycle read pipe; lo-word read freezes the hi word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs.readdata      <= '0;
      avs.readdatavalid <= 1'b0;
      snapshot          <= '0;
    end else begin
      avs.readdatavalid <= rd;
      if (rd)
        avs.readdata <= rdata;
      if (rd && addr == ADDR_W'(ADDR_SOL_LO))
        snapshot <= solution[63:32];
    end
  end

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Bench for sha3_miner_csr: directed steps plus
// random register traffic against a word-level model.
module tb_sha3_miner_csr;

  localparam logic [31:0] VER = 32'h5348_3301;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_miner_csr_if #(.ADDR_W(5)) bus ();

  logic [255:0] header;
  logic [255:0] difficulty;
  logic [63:0]  start_nonce;
  logic [18:0]  control;
  logic [63:0]  solution;
  logic [2:0]   status;
  logic         miner_irq;
  logic         irq;

  sha3_miner_csr #(.VERSION(VER), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .avs         (bus),
    .header      (header),
    .difficulty  (difficulty),
    .start_nonce (start_nonce),
    .control     (control),
    .solution    (solution),
    .status      (status),
    .miner_irq   (miner_irq),
    .irq         (irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] jm [18];
  logic [18:0] m_ctl;
  logic        m_lerr;
  logic        m_pend;
  logic        m_en;
  logic [31:0] m_snap;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 18; k++) jm[k] = '0;
    m_ctl  = '0;
    m_lerr = 1'b0;
    m_pend = 1'b0;
    m_en   = 1'b0;
    m_snap = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic m_write(input logic [4:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be);
    logic [31:0] t;
    if (a <= 5'h11) begin
      if (m_ctl[0]) m_lerr = 1'b1;
      else jm[int'(a)] = merge(jm[int'(a)], d, be);
    end else begin
      case (a)
        5'h12: begin
          t = merge({13'b0, m_ctl}, d, be);
          m_ctl = t[18:0];
        end
        5'h13: if (be[0] && d[3]) m_lerr = 1'b0;
        5'h16: if (be[0] && d[0]) m_pend = 1'b0;
        5'h17: if (be[0]) m_en = d[0];
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a <= 5'h11) return jm[int'(a)];
    case (a)
      5'h12: return {13'b0, m_ctl};
      5'h13: return {28'b0, m_lerr, status};
      5'h14: return solution[31:0];
      5'h15: return m_snap;
      5'h16: return {31'b0, m_pend};
      5'h17: return {31'b0, m_en};
      5'h18: return VER;
      default: return 32'h0;
    endcase
  endfunction

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    bus.write      = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    m_write(a, d, be);
  endtask

  task automatic rd(input logic [4:0] a,
                    input string tag,
                    output logic [31:0] got);
    logic [31:0] exp;
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    exp = mread(a);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    got = bus.readdata;
    chk({tag, "_valid"}, bus.readdatavalid, 1);
    chk(tag, got, exp);
    if (a == 5'h14) m_snap = solution[63:32];
  endtask

  task automatic chk_outs(input string tag);
    logic [255:0] h;
    logic [255:0] df;
    for (int k = 0; k < 8; k++) begin
      h[32*k +: 32]  = jm[k];
      df[32*k +: 32] = jm[8+k];
    end
    chk({tag, "_header"}, header, h);
    chk({tag, "_diff"}, difficulty, df);
    chk({tag, "_nonce"}, start_nonce, {jm[17], jm[16]});
    chk({tag, "_control"}, control, m_ctl);
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;

    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    solution  = '0;
    status    = '0;
    miner_irq = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", bus.readdatavalid, 0);
    chk("rst_rdata", bus.readdata, 0);
    chk("rst_irq", irq, 0);
    chk_outs("rst");

    rd(5'h12, "ctl0", v);
    chk("ctl0_const", v, 0);
    rd(5'h00, "hdr0", v);
    chk("hdr0_const", v, 0);
    rd(5'h18, "version", v);
    chk("version_const", v, VER);
    @(posedge clk);
    #1;
    chk("valid_pulse", bus.readdatavalid, 0);
    chk("rdata_hold", bus.readdata, VER);

    wr(5'h03, 32'h1122_3344, 4'b0101);
    rd(5'h03, "be_word", v);
    chk("be_word_const", v, 32'h0022_0044);
    chk("be_header", header[127:96], 32'h0022_0044);

    @(negedge clk);
    bus.address    = 5'h17;
    bus.writedata  = 32'h1;
    bus.byteenable = 4'hF;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    m_write(5'h17, 32'h1, 4'hF);
    chk("rw_no_valid", bus.readdatavalid, 0);
    rd(5'h17, "rw_write_done", v);
    chk("rw_en_const", v, 1);
    wr(5'h17, 32'h0, 4'hF);

    wr(5'h12, 32'h1, 4'hF);
    wr(5'h10, 32'hDEAD_BEEF, 4'hF);
    chk("locked_nonce", start_nonce, 0);
    rd(5'h13, "lock_status", v);
    chk("lock_err_set", v[3], 1);
    wr(5'h13, 32'h8, 4'hF);
    rd(5'h13, "lock_clr", v);
    chk("lock_err_clr", v[3], 0);
    wr(5'h12, 32'h0, 4'hF);
    wr(5'h10, 32'hDEAD_BEEF, 4'hF);
    chk("unlock_nonce", start_nonce[31:0], 32'hDEAD_BEEF);

    solution = 64'h0000_0001_FFFF_FFFF;
    rd(5'h14, "sol_lo", v);
    chk("sol_lo_const", v, 32'hFFFF_FFFF);
    solution = 64'h0000_0002_0000_0000;
    rd(5'h15, "sol_hi", v);
    chk("sol_hi_const", v, 32'h1);

    for (int i = 0; i < 200; i++) begin
      solution = {$urandom, $urandom};
      status   = 3'($urandom_range(0, 7));
      a  = 5'($urandom_range(0, 31));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      if (a == 5'h13 || a == 5'h16) be = 4'hF;
      if ($urandom_range(0, 1) == 1)
        wr(a, d, be);
      else
        rd(a, "rnd_read", v);
      chk_outs("rnd");
      chk("rnd_irq", irq, m_pend & m_en);
    end

    wr(5'h12, 32'h0, 4'hF);
    wr(5'h17, 32'h1, 4'hF);
    @(negedge clk);
    miner_irq = 1'b1;
    @(posedge clk);
    #1;
    m_pend = 1'b1;
    chk("irq_lag", irq, 0);
    @(posedge clk);
    #1;
    chk("irq_high", irq, 1);
    rd(5'h16, "pend_set", v);
    chk("pend_set_const", v, 1);
    wr(5'h16, 32'h1, 4'hF);
    rd(5'h16, "pend_w1c", v);
    chk("pend_w1c_const", v, 0);
    chk("irq_low", irq, 0);

    @(negedge clk);
    miner_irq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    miner_irq      = 1'b1;
    bus.address    = 5'h16;
    bus.writedata  = 32'h1;
    bus.byteenable = 4'hF;
    bus.write      = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    m_pend = 1'b1;
    rd(5'h16, "set_wins", v);
    chk("set_wins_const", v, 1);
    chk("irq_again", irq, 1);

    @(negedge clk);
    bus.address = 5'h18;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", bus.readdatavalid, 1);
    chk("pre_rst_irq", irq, 1);
    #1;
    rst_n = 1'b0;
    #1;
    bus.read = 1'b0;
    chk("arst_valid", bus.readdatavalid, 0);
    chk("arst_irq", irq, 0);
    chk("arst_rdata", bus.readdata, 0);
    model_reset();
    chk_outs("arst");
    miner_irq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(5'h16, "post_pend", v);
    chk("post_pend_const", v, 0);
    rd(5'h17, "post_en", v);
    rd(5'h13, "post_status", v);
    rd(5'h15, "post_snap", v);
    chk("post_snap_const", v, 0);
    chk_outs("post");
    chk("post_irq", irq, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_miner_csr.md
Name: sha3_miner_csr

Overview: Avalon-MM slave register file that sits directly upstream of sha3_256_miner and also consumes its outputs. It holds header, difficulty, start_nonce and control for the miner, and exposes solution and status to the HPS. It latches the miner's level irq into a software-clearable pending bit with an enable mask. It provides a coherent 64-bit solution read and locks the job registers while the miner runs.

Parameters:
VERSION, 32'h5348_3301, constant returned at the version address
ADDR_W, 5, word-address width (32 words decoded)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  reset, asynchronous assert, active-low
avs_address  in  ADDR_W  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_byteenable  in  4  byte lanes for writes
avs_readdata  out  32  read data
avs_readdatavalid  out  1  read data qualifier
header  out  256  to miner header
difficulty  out  256  to miner difficulty
start_nonce  out  64  to miner start_nonce
control  out  19  to miner control
solution  in  64  from miner solution
status  in  3  from miner status {test, run, match}
miner_irq  in  1  from miner irq (level)
irq  out  1  interrupt to HPS

Behaviour:
- Reset: all registers, header, difficulty, start_nonce, control, avs_readdata, avs_readdatavalid, irq, pending, enable, lock_err and snapshot clear to 0.
- Address map (word): 0x00-0x07 header[32k+31:32k], RW. 0x08-0x0F difficulty, same order, RW. 0x10/0x11 start_nonce lo/hi, RW. 0x12 control[18:0], RW (upper bits read 0). 0x13 status: {28'b0, lock_err, status[2:0]}, RO except W1C on bit3. 0x14 solution[31:0]; the read captures solution[63:32] into the snapshot in the same cycle. 0x15 returns the snapshot. 0x16 pending bit0, W1C. 0x17 enable bit0, RW. 0x18 returns VERSION. All other addresses read 0; writes to them are ignored.
- Writes: one cycle. Writes to RW registers honour avs_byteenable per byte. No waitrequest.
- Write lock: while control[0] is 1, writes to 0x00-0x11 are dropped and set lock_err (sticky). Writes to control are never locked. Clearing run unlocks the job registers on the next cycle.
- Reads: fixed latency 1. avs_readdatavalid pulses 1 cycle after avs_read. avs_readdata holds its last value otherwise. Back-to-back reads are supported every cycle.
- Read and write in the same cycle: the write executes; the read is ignored and no readdatavalid is produced.
- Interrupt: miner_irq_d is registered. pending is set on a rising edge (miner_irq & ~miner_irq_d). A W1C on bit0 clears pending. If set and clear occur in the same cycle, set wins. irq = pending & enable, registered (1 cycle after pending/enable changes).
- The snapshot is updated only by reads of 0x14. Reading 0x15 without a prior 0x14 read returns the stale snapshot (0 after reset).
- Outputs to the miner are direct register outputs with no extra latency; the miner synchronizes control itself.
- rst_n asserted mid-transaction: any in-flight readdatavalid is cancelled and the irq output drops immediately (asynchronous).

Decomposition:
- Shared package sha3_miner_pkg: address constants (ADDR_HEADER0 = 0x00, ADDR_DIFF0 = 0x08, ADDR_NONCE_LO = 0x10, ADDR_NONCE_HI = 0x11, ADDR_CONTROL = 0x12, ADDR_STATUS = 0x13, ADDR_SOL_LO = 0x14, ADDR_SOL_HI = 0x15, ADDR_IRQ_PEND = 0x16, ADDR_IRQ_EN = 0x17, ADDR_VERSION = 0x18), control bit positions (RUN = 0, TEST = 1, HALT = 2, PADL = 10:3, PADF = 18:11), VERSION default.
- One natural sub-module: csr_byte_reg32, a 32-bit register with byte-enable write and lock input, instantiated for header, difficulty and nonce words.

Test Plan:
- After reset, read 0x18 -> readdatavalid one cycle later with 0x53483301. Read 0x12 and 0x00 -> 0.
- Write 0x11223344 to 0x03 with byteenable 4'b0101, then read 0x03 -> 0x00220044. Check header[127:96] = 0x00220044.
- Write control = 1 (run), then write 0x10 = 0xDEADBEEF -> start_nonce unchanged and status read shows bit3 = 1. W1C 0x8 to 0x13 -> bit3 = 0. Clear run, rewrite 0x10 -> start_nonce[31:0] = 0xDEADBEEF.
- Drive solution = 0x00000001_FFFFFFFF and read 0x14 -> 0xFFFFFFFF. Change solution to 0x00000002_00000000, then read 0x15 -> 0x00000001.
- Enable = 1 and raise miner_irq -> pending = 1, irq high 1 cycle after pending. Hold miner_irq high and W1C 0x16 -> pending clears and does not re-set. Assert a W1C in the same cycle as a new rising edge -> pending stays 1.
- Assert rst_n low asynchronously while a read is pending and irq = 1 -> irq and avs_readdatavalid go 0 immediately, and all outputs read 0 after release.
